// File: rtl/smi_eth_pkg.sv
// Shared constants for the SMI Ethernet adaptors: header layout and the
// transmit adaptor's state encoding.
package smi_eth_pkg;

   localparam logic [7:0] ETHERNET_FRAME_ID_BYTE = 8'h40;
   localparam int         HDR_ID_BYTE            = 0;
   localparam int         HDR_USER_BYTE          = 1;
   localparam int         HDR_ABORT_BIT          = 7;
   localparam int         HDR_BYTES              = 2;

   typedef enum logic [1:0] {
      HEAD,
      BODY,
      FLUSH,
      DROP
   } state_t;

endpackage

// File: rtl/smi_eth_eofc_to_keep.sv
// Byte count to contiguous-from-LSB keep mask; counts above KeepWidth
// saturate to all ones.
module smi_eth_eofc_to_keep #(
   parameter int KeepWidth = 8
) (
   input  logic [7:0]           count,
   output logic [KeepWidth-1:0] keep
);

   always_comb begin
      // NOTE: default assignment first so no path through the block infers a latch.
      keep = '0;
      for (int i = 0; i < KeepWidth; i++) begin
         keep[i] = (i < int'(count));
      end
   end

endmodule

// File: rtl/smi_eth_axis_output_adaptor.sv
// SMI Ethernet frames to AXI Stream: strips the 2-byte header, realigns the
// payload down by 2 bytes. Optional SMI_ETH_AXIS_OUT_ABORT_EN marks aborted frames.
module smi_eth_axis_output_adaptor
   import smi_eth_pkg::*;
#(
   parameter  int DataIndexSize = 3,
   parameter  int UserWidth     = 1,
   localparam int DataWidth     = (1 << DataIndexSize) * 8,
   localparam int KeepWidth     = (1 << DataIndexSize)
) (
   input  logic                 ethClk,
   input  logic                 ethRst,
   input  logic                 smiInValid,
   input  logic [DataWidth-1:0] smiInData,
   input  logic [7:0]           smiInEofc,
   output logic                 smiInStop,
   output logic                 axisOutValid,
   output logic [DataWidth-1:0] axisOutData,
   output logic [KeepWidth-1:0] axisOutKeep,
   output logic [UserWidth-1:0] axisOutUser,
   output logic                 axisOutLast,
   input  logic                 axisOutReady,
   input  logic                 frmDropCountReset,
   output logic [31:0]          frmDropCount
);

   localparam int         HdrWidth  = HDR_BYTES * 8;
   localparam logic [7:0] FlitBytes = 8'(KeepWidth);

   state_t                     state;
   logic [DataWidth-HdrWidth-1:0] residual;
   logic [7:0]                 pending;
   logic [UserWidth-1:0]       frame_user;
   logic [7:0]                 eofc, keep_count;
   logic [KeepWidth-1:0]       keep_mask, next_keep;
   logic [DataWidth-1:0]       raw_data, next_data;
   logic [UserWidth-1:0]       in_user, head_last_user, body_last_user;
   logic                       in_xfer, out_free, hdr_ok, drop_inc, unused_hdr;

   assign smiInStop  = ethRst | (axisOutValid & ~axisOutReady) | (state == FLUSH);
   assign in_xfer    = smiInValid & ~smiInStop;
   assign out_free   = ~axisOutValid | axisOutReady;
   assign eofc       = (smiInEofc > FlitBytes) ? FlitBytes : smiInEofc;
   assign hdr_ok     = smiInData[HDR_ID_BYTE*8 +: 8] == ETHERNET_FRAME_ID_BYTE;
   assign in_user    = smiInData[HDR_USER_BYTE*8 +: UserWidth];
   assign unused_hdr = ^smiInData[HDR_USER_BYTE*8 +: 8];
   assign drop_inc   = in_xfer & (state == HEAD) & (~hdr_ok | (eofc == 8'd1) | (eofc == 8'd2));

`ifdef SMI_ETH_AXIS_OUT_ABORT_EN
   logic frame_abort, in_abort;
   assign in_abort       = smiInData[HDR_USER_BYTE*8 + HDR_ABORT_BIT];
   assign head_last_user = in_user | UserWidth'(in_abort);
   assign body_last_user = frame_user | UserWidth'(frame_abort);

   always_ff @(posedge ethClk) begin
      if (ethRst)
         frame_abort <= 1'b0;
      else if (state == HEAD && in_xfer && hdr_ok && eofc == 8'd0)
         frame_abort <= in_abort;
   end
`else
   assign head_last_user = in_user;
   assign body_last_user = frame_user;
`endif

   // One keep decoder serves all three emitting states; the count it sees
   // is the number of valid bytes in the beat that state would produce.
   always_comb begin
      keep_count = '0;
      raw_data   = '0;
      case (state)
         HEAD:  begin
            keep_count = eofc - 8'd2;
            raw_data   = {{HdrWidth{1'b0}}, smiInData[DataWidth-1:HdrWidth]};
         end
         BODY:  begin
            keep_count = FlitBytes - 8'd2 + eofc;
            raw_data   = {smiInData[HdrWidth-1:0], residual};
         end
         FLUSH: begin
            keep_count = pending;
            raw_data   = {{HdrWidth{1'b0}}, residual};
         end
         default: ;
      endcase
   end

   smi_eth_eofc_to_keep #(.KeepWidth(KeepWidth)) u_keep (
      .count (keep_count),
      .keep  (keep_mask)
   );

   assign next_keep = (state == BODY && eofc == 8'd0) ? '1 : keep_mask;

   always_comb begin
      next_data = '0;
      for (int b = 0; b < KeepWidth; b++) begin
         next_data[b*8 +: 8] = raw_data[b*8 +: 8] & {8{next_keep[b]}};
      end
   end

   always_ff @(posedge ethClk) begin
      if (ethRst) begin
         // NOTE: every register, data path included, is reset so outputs never show stale bytes.
         state        <= HEAD;
         residual     <= '0;
         pending      <= '0;
         frame_user   <= '0;
         axisOutValid <= 1'b0;
         axisOutData  <= '0;
         axisOutKeep  <= '0;
         axisOutUser  <= '0;
         axisOutLast  <= 1'b0;
         frmDropCount <= '0;
      end else begin
         if (axisOutValid && axisOutReady)
            axisOutValid <= 1'b0;

         if (frmDropCountReset)
            frmDropCount <= '0;
         else if (drop_inc && frmDropCount != '1)
            frmDropCount <= frmDropCount + 32'd1;

         case (state)
            HEAD: if (in_xfer) begin
               if (!hdr_ok) begin
                  if (eofc == 8'd0) state <= DROP;
               end else if (eofc == 8'd0) begin
                  residual   <= smiInData[DataWidth-1:HdrWidth];
                  frame_user <= in_user;
                  state      <= BODY;
               end else if (eofc > 8'd2) begin
                  axisOutValid <= 1'b1;
                  axisOutData  <= next_data;
                  axisOutKeep  <= next_keep;
                  axisOutLast  <= 1'b1;
                  axisOutUser  <= head_last_user;
               end
            end
            BODY: if (in_xfer) begin
               axisOutValid <= 1'b1;
               axisOutData  <= next_data;
               axisOutKeep  <= next_keep;
               residual     <= smiInData[DataWidth-1:HdrWidth];
               if (eofc == 8'd0) begin
                  axisOutLast <= 1'b0;
                  axisOutUser <= frame_user;
               end else if (eofc <= 8'd2) begin
                  axisOutLast <= 1'b1;
                  axisOutUser <= body_last_user;
                  state       <= HEAD;
               end else begin
                  axisOutLast <= 1'b0;
                  axisOutUser <= frame_user;
                  pending     <= eofc - 8'd2;
                  state       <= FLUSH;
               end
            end
            FLUSH: if (out_free) begin
               axisOutValid <= 1'b1;
               axisOutData  <= next_data;
               axisOutKeep  <= next_keep;
               axisOutLast  <= 1'b1;
               axisOutUser  <= body_last_user;
               state        <= HEAD;
            end
            DROP: if (in_xfer && eofc != 8'd0) state <= HEAD;
            default: state <= HEAD;
         endcase
      end
   end

endmodule

// File: tb/tb_smi_eth_axis_output_adaptor.sv
// Randomised and directed bench for smi_eth_axis_output_adaptor against a
// frame-level reference model (header check, strip, 2-byte realignment).
module tb_smi_eth_axis_output_adaptor;

   localparam int KW = 8;
   localparam int DW = KW * 8;
   localparam int UW = 1;

   logic          ethClk = 1'b0;
   logic          ethRst;
   logic          smiInValid;
   logic [DW-1:0] smiInData;
   logic [7:0]    smiInEofc;
   logic          smiInStop;
   logic          axisOutValid;
   logic [DW-1:0] axisOutData;
   logic [KW-1:0] axisOutKeep;
   logic [UW-1:0] axisOutUser;
   logic          axisOutLast;
   logic          axisOutReady;
   logic          frmDropCountReset;
   logic [31:0]   frmDropCount;

   always #5 ethClk = ~ethClk;

   smi_eth_axis_output_adaptor #(.DataIndexSize(3), .UserWidth(UW)) dut (
      .ethClk            (ethClk),
      .ethRst            (ethRst),
      .smiInValid        (smiInValid),
      .smiInData         (smiInData),
      .smiInEofc         (smiInEofc),
      .smiInStop         (smiInStop),
      .axisOutValid      (axisOutValid),
      .axisOutData       (axisOutData),
      .axisOutKeep       (axisOutKeep),
      .axisOutUser       (axisOutUser),
      .axisOutLast       (axisOutLast),
      .axisOutReady      (axisOutReady),
      .frmDropCountReset (frmDropCountReset),
      .frmDropCount      (frmDropCount)
   );

   typedef struct packed {
      logic [DW-1:0] data;
      logic [KW-1:0] keep;
      logic [UW-1:0] user;
      logic          last;
   } beat_t;

   beat_t      exp_q[$];
   beat_t      got_q[$];
   logic [7:0] frame_b[$];
   int         checks = 0;
   int         errors = 0;
   int         exp_drops = 0;
   int         stop_cycles = 0;
   bit         rand_gap = 0;

   // Collect every AXIS beat that transfers, sampled mid-cycle.
   always @(negedge ethClk) begin
      if (axisOutValid === 1'b1 && axisOutReady === 1'b1)
         got_q.push_back({axisOutData, axisOutKeep, axisOutUser, axisOutLast});
      if (smiInStop === 1'b1) stop_cycles++;
   end

   task automatic tick();
      @(posedge ethClk);
      #1;
   endtask

   task automatic build_frame(input int len, input logic [7:0] b0, input logic [7:0] b1);
      frame_b.delete();
      frame_b.push_back(b0);
      if (len > 1) frame_b.push_back(b1);
      for (int i = 2; i < len; i++) frame_b.push_back(8'($urandom));
   endtask

   // Reference: a frame is a byte string; good frames yield the bytes after the
   // header cut into KW-byte beats, the last one partial.
   task automatic model_frame();
      int         len, plen, n;
      beat_t      b;
      len = frame_b.size();
      if (frame_b[0] != 8'h40 || len <= 2) begin
         exp_drops++;
         return;
      end
      plen = len - 2;
      for (int s = 0; s < plen; s += KW) begin
         n = (plen - s < KW) ? plen - s : KW;
         b = '0;
         for (int j = 0; j < n; j++) begin
            b.data[j*8 +: 8] = frame_b[2 + s + j];
            b.keep[j]        = 1'b1;
         end
         b.last = (s + KW >= plen);
         b.user = frame_b[1][UW-1:0];
`ifdef SMI_ETH_AXIS_OUT_ABORT_EN
         if (b.last && frame_b[1][7]) b.user[0] = 1'b1;
`endif
         exp_q.push_back(b);
      end
   endtask

   function automatic logic [DW-1:0] flit_data(input int f);
      logic [DW-1:0] d;
      d = {$urandom, $urandom};
      for (int j = 0; j < KW; j++)
         if (f*KW + j < frame_b.size()) d[j*8 +: 8] = frame_b[f*KW + j];
      return d;
   endfunction

   task automatic send_flit(input logic [DW-1:0] d, input logic [7:0] e);
      int n;
      bit acc;
      if (rand_gap && $urandom_range(0, 3) == 0) tick();
      smiInValid = 1'b1;
      smiInData  = d;
      smiInEofc  = e;
      n = 0;
      do begin
         @(negedge ethClk);
         acc = (smiInStop === 1'b0);
         tick();
         n++;
      end while (!acc && n < 500);
      if (!acc) begin
         checks++;
         errors++;
         $display("FAIL flit_accept: smiInStop still %b after %0d cycles, required 0", smiInStop, n);
      end
      smiInValid = 1'b0;
      smiInEofc  = 8'd0;
   endtask

   task automatic drive_frame(input logic [7:0] eofc_override);
      int         nfl;
      logic [7:0] e;
      nfl = (frame_b.size() + KW - 1) / KW;
      for (int f = 0; f < nfl; f++) begin
         e = (f == nfl - 1) ? 8'(frame_b.size() - f*KW) : 8'd0;
         if (f == nfl - 1 && eofc_override != 8'd0) e = eofc_override;
         send_flit(flit_data(f), e);
      end
   endtask

   task automatic run_frame(input int len, input logic [7:0] b0, input logic [7:0] b1);
      build_frame(len, b0, b1);
      model_frame();
      drive_frame(8'd0);
   endtask

   // Drain the output, then compare collected beats and drop count with the model.
   task automatic scoreboard(input string name);
      int n;
      axisOutReady = 1'b1;
      n = 0;
      while (got_q.size() < exp_q.size() && n < 2000) begin
         tick();
         n++;
      end
      repeat (4) tick();
      checks++;
      if (got_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL %s beat_count: got %0d, expected %0d", name, got_q.size(), exp_q.size());
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL %s beat %0d: got data=%h keep=%h user=%h last=%b, expected data=%h keep=%h user=%h last=%b",
                     name, i, got_q[i].data, got_q[i].keep, got_q[i].user, got_q[i].last,
                     exp_q[i].data, exp_q[i].keep, exp_q[i].user, exp_q[i].last);
         end
      end
      checks++;
      if (frmDropCount !== 32'(exp_drops)) begin
         errors++;
         $display("FAIL %s drop_count: got %0d, expected %0d", name, frmDropCount, exp_drops);
      end
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic test_reset();
      ethRst = 1'b1;
      smiInValid = 1'b0;
      smiInData = '0;
      smiInEofc = 8'd0;
      axisOutReady = 1'b1;
      frmDropCountReset = 1'b0;
      repeat (3) tick();
      checks += 3;
      if (smiInStop !== 1'b1) begin errors++; $display("FAIL reset_stop: got %b, expected 1", smiInStop); end
      if ({axisOutValid, axisOutLast, axisOutKeep, axisOutUser} !== '0 || axisOutData !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got valid=%b last=%b keep=%h user=%h data=%h, expected all 0",
                  axisOutValid, axisOutLast, axisOutKeep, axisOutUser, axisOutData);
      end
      if (frmDropCount !== 32'd0) begin errors++; $display("FAIL reset_count: got %0d, expected 0", frmDropCount); end
      ethRst = 1'b0;
      #1;
      checks++;
      if (smiInStop !== 1'b0) begin errors++; $display("FAIL post_reset_stop: got %b, expected 0", smiInStop); end
      exp_drops = 0;
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic test_merge();
      run_frame(10, 8'h40, 8'h03);
      scoreboard("merge");
   endtask

   task automatic test_flush();
      tick();
      stop_cycles = 0;
      run_frame(14, 8'h40, 8'h00);
      scoreboard("flush");
      checks++;
      if (stop_cycles != 1) begin
         errors++;
         $display("FAIL flush_stop_cycles: got %0d, expected 1", stop_cycles);
      end
   endtask

   task automatic test_bad_header();
      run_frame(20, 8'h41, 8'h00);
      run_frame(12, 8'h40, 8'h01);
      run_frame(5, 8'h00, 8'h01);
      run_frame(9, 8'h40, 8'h00);
      scoreboard("bad_header");
   endtask

   task automatic test_runt();
      run_frame(2, 8'h40, 8'h00);
      run_frame(1, 8'h40, 8'h00);
      run_frame(5, 8'h40, 8'h00);
      build_frame(KW, 8'h40, 8'h01);
      model_frame();
      drive_frame(8'd200);
      scoreboard("runt_and_clamp");
   endtask

   task automatic test_backpressure();
      logic [DW-1:0] held;
      axisOutReady = 1'b1;
      build_frame(24, 8'h40, 8'h01);
      model_frame();
      send_flit(flit_data(0), 8'd0);
      send_flit(flit_data(1), 8'd0);
      axisOutReady = 1'b0;
      smiInValid = 1'b1;
      smiInData = flit_data(2);
      smiInEofc = 8'd8;
      held = axisOutData;
      repeat (5) begin
         @(negedge ethClk);
         checks += 2;
         if (smiInStop !== 1'b1) begin errors++; $display("FAIL stall_stop: got %b, expected 1", smiInStop); end
         if (axisOutData !== held) begin errors++; $display("FAIL stall_hold: got %h, expected %h", axisOutData, held); end
         tick();
      end
      axisOutReady = 1'b1;
      send_flit(smiInData, 8'd8);
      scoreboard("backpressure");
   endtask

   task automatic test_abort();
      run_frame(14, 8'h40, 8'h80);
      run_frame(6, 8'h40, 8'h80);
      run_frame(12, 8'h40, 8'h00);
      scoreboard("abort");
   endtask

   task automatic test_drop_count_reset();
      frmDropCountReset = 1'b1;
      build_frame(2, 8'h40, 8'h00);
      drive_frame(8'd0);
      frmDropCountReset = 1'b0;
      exp_drops = 0;
      checks++;
      if (frmDropCount !== 32'd0) begin
         errors++;
         $display("FAIL count_reset_priority: got %0d, expected 0", frmDropCount);
      end
      run_frame(2, 8'h40, 8'h00);
      scoreboard("count_reset");
   endtask

   task automatic test_random();
      bit         done;
      logic [7:0] b0;
      done = 0;
      rand_gap = 1;
      fork
         begin
            for (int k = 0; k < 100; k++) begin
               b0 = 8'h40;
               if ($urandom_range(0, 7) == 0) begin
                  b0 = 8'($urandom);
                  if (b0 == 8'h40) b0 = 8'h00;
               end
               run_frame($urandom_range(1, 4*KW), b0, 8'($urandom));
            end
            done = 1;
         end
         begin
            while (!done) begin
               axisOutReady = ($urandom_range(0, 2) != 0);
               tick();
            end
         end
      join
      rand_gap = 0;
      scoreboard("random");
   endtask

   task automatic test_reset_mid_body();
      beat_t first;
      axisOutReady = 1'b1;
      build_frame(30, 8'h40, 8'h01);
      model_frame();
      first = exp_q[0];
      exp_q.delete();
      exp_q.push_back(first);
      send_flit(flit_data(0), 8'd0);
      send_flit(flit_data(1), 8'd0);
      ethRst = 1'b1;
      tick();
      checks++;
      if (axisOutValid !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_body_valid: got %b, expected 0", axisOutValid);
      end
      ethRst = 1'b0;
      exp_drops = 0;
      run_frame(12, 8'h40, 8'h00);
      scoreboard("reset_mid_body");
   endtask

   initial begin
      test_reset();
      test_merge();
      test_flush();
      test_bad_header();
      test_runt();
      test_backpressure();
      test_abort();
      test_drop_count_reset();
      test_random();
      test_reset_mid_body();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
